fabric_bitstream_checker: RTL
=============================

Name: fabric_bitstream_checker

Overview:
- Sits between the bitstream source multiplexer (SPI controller or SPI receiver) and fabric_config, in the core's bitstream path.
- Hunts for a sync word, then parses a one-word header carrying the payload length.
- Forwards exactly that many payload words to fabric_config, then compares a trailing CRC-32 against the CRC computed over the payload.
- Reports done, pass/fail and an error code so the core can gate warmboot and flag corrupt images.

Parameters:
- SYNC_WORD, 32'hFAB0_FAB1, word that starts a bitstream.
- HEADER_VERSION, 8'h01, required value of header[31:24].
- MAX_WORDS, 16'h1762, largest legal payload length in words.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- bitstream_valid_i  input  1  input word strobe, one word per cycle when high
- bitstream_data_i  input  32  input word
- clear_i  input  1  synchronous clear of state and sticky flags
- bitstream_valid_o  output  1  payload word strobe to fabric_config
- bitstream_data_o  output  32  payload word to fabric_config
- busy_o  output  1  high in HEADER, PAYLOAD and CRC states
- done_o  output  1  one-cycle pulse when a CRC word has been checked
- crc_ok_o  output  1  sticky: last completed bitstream passed CRC
- error_o  output  1  sticky: any error since last clear/reset
- error_code_o  output  2  0 none, 1 bad header, 2 CRC mismatch

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, word counter 0, CRC register 32'hFFFF_FFFF.
- A word is accepted only in a cycle with bitstream_valid_i=1. Idle cycles between words are legal in every state.
- IDLE:
  - accepted word == SYNC_WORD -> HEADER, CRC register set to 32'hFFFF_FFFF, crc_ok_o cleared.
  - any other word is dropped.
- HEADER:
  - accepted word with [31:24]==HEADER_VERSION, [23:16]==0, 1<=[15:0]<=MAX_WORDS -> load counter with [15:0], go to PAYLOAD.
  - otherwise error_o=1, error_code_o=1, return to IDLE.
  - The header word is not forwarded.
- PAYLOAD:
  - each accepted word is forwarded, with bitstream_valid_o and bitstream_data_o registered one cycle after acceptance.
  - CRC updated with the word, counter decremented.
  - when counter reaches 1 on an accepted word -> CRC.
  - A word equal to SYNC_WORD inside the payload is ordinary data; no resync.
- CRC:
  - accepted word compared to ~crc_reg.
  - done_o pulses the cycle after acceptance.
  - on match, crc_ok_o=1.
  - on mismatch, error_o=1 and error_code_o=2.
  - return to IDLE. The CRC word is not forwarded.
- CRC-32 definition:
  - polynomial 32'h04C11DB7, init 32'hFFFF_FFFF, no reflection, final XOR 32'hFFFF_FFFF.
  - word fed MSB (bit 31) first.
  - whole 32-bit update computed combinationally in one cycle.
- Throughput: one word per cycle sustained, no backpressure.
- Sticky flags:
  - error_o and error_code_o hold until clear_i or reset.
  - a later error overwrites the code.
  - a subsequent good bitstream does not clear error_o.
- clear_i:
  - next cycle: state IDLE, error_o=0, error_code_o=0, crc_ok_o=0, done_o=0, bitstream_valid_o=0.
  - the same-cycle input word is discarded.
  - clear_i takes priority over bitstream_valid_i.
- Reset mid-operation: immediate return to reset values. No partial-word output occurs after rst_ni falls.
- busy_o is combinational from the state (no extra latency).

Decomposition:
- Package fabric_bitstream_pkg holds:
  - state enum {IDLE, HEADER, PAYLOAD, CRC}
  - error code enum {ERR_NONE, ERR_HEADER, ERR_CRC}
  - CRC_POLY and CRC_INIT constants
  - function crc32_word(crc, data) returning the next CRC.
- One combinational sub-module, fabric_crc32_word, wraps crc32_word so it can be unit-tested standalone. The FSM, counter and output registers stay in the top module.

Test Plan:
- Good image: noise 32'h1234_5678, then SYNC, header 32'h0100_0003, payload 32'hA, 32'hB, 32'hC, correct CRC from golden model.
  - Required: exactly 3 output strobes carrying A, B, C, each one cycle after input.
  - done_o pulses once, crc_ok_o=1, error_o=0, busy_o low after the CRC word.
- Corrupt CRC: same image with CRC bit 0 flipped.
  - Required: A, B, C still forwarded; done_o pulses; error_code_o=2, error_o=1, crc_ok_o=0.
- Bad header cases: header 32'h0200_0003, then 32'h0100_0000, then 32'h0100_1763, each after SYNC.
  - Required: error_code_o=1, no output strobes, state back in IDLE.
  - A following good image forwards its payload with error_o still 1.
- Gaps and in-payload sync: random valid gaps of 0–5 cycles, with SYNC_WORD placed as payload word 2 of 4.
  - Required: all 4 words forwarded in order, CRC passes, no resync.
- Reset and clear mid-payload: rst_ni low after 2 of 5 payload words.
  - Required: outputs zero immediately, later good image passes.
  - Repeat with clear_i: same result, sticky error cleared the next cycle.
- CRC unit test: fabric_crc32_word driven with random (crc, data) pairs.
  - Required: output equals the software bitwise model for 10,000 vectors.

Source files
------------

// File: rtl/fabric_bitstream_pkg.sv
// Shared types, CRC-32 constants and the single-cycle word-wide CRC update
// used by the bitstream checker.
package fabric_bitstream_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      PAYLOAD = 2'd2,
      CRC     = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'd0,
      ERR_HEADER = 2'd1,
      ERR_CRC    = 2'd2
   } err_e;

   localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

   // Non-reflected CRC-32 step over a full word, bit 31 consumed first.
   function automatic logic [31:0] crc32_word(input logic [31:0] crc,
                                              input logic [31:0] data);
      logic [31:0] c;
      logic [31:0] d;
      c = crc;
      d = data;
      for (int unsigned i = 0; i < 32; i++) begin
         if (c[31] ^ d[31]) c = (c << 1) ^ CRC_POLY;
         else               c = c << 1;
         d = d << 1;
      end
      return c;
   endfunction

endpackage

// File: rtl/fabric_crc32_word.sv
// Combinational one-word CRC-32 update, split out so it can be checked on its own.
module fabric_crc32_word
   import fabric_bitstream_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [31:0] data_i,
   output logic [31:0] crc_o
);

   assign crc_o = crc32_word(crc_i, data_i);

endmodule

// File: rtl/fabric_bitstream_checker.sv
// Sync hunt, header parse, payload forwarding and trailing CRC-32 check
// between the bitstream source mux and fabric_config.
module fabric_bitstream_checker
   import fabric_bitstream_pkg::*;
#(
   parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
   parameter logic [7:0]  HEADER_VERSION = 8'h01,
   parameter logic [15:0] MAX_WORDS      = 16'h1762
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        bitstream_valid_i,
   input  logic [31:0] bitstream_data_i,
   input  logic        clear_i,
   output logic        bitstream_valid_o,
   output logic [31:0] bitstream_data_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        crc_ok_o,
   output logic        error_o,
   output logic [1:0]  error_code_o
);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] crc_q, crc_d, crc_next;
   logic        vld_q, vld_d;
   logic [31:0] data_q, data_d;
   logic        done_q, done_d;
   logic        ok_q, ok_d;
   logic        err_q, err_d;
   err_e        code_q, code_d;
   logic [15:0] hdr_len;
   logic        hdr_ok;

   fabric_crc32_word u_crc (
      .crc_i  (crc_q),
      .data_i (bitstream_data_i),
      .crc_o  (crc_next)
   );

   assign hdr_len = bitstream_data_i[15:0];
   assign hdr_ok  = (bitstream_data_i[31:24] == HEADER_VERSION) &&
                    (bitstream_data_i[23:16] == 8'h00) &&
                    (hdr_len != 16'h0000) && (hdr_len <= MAX_WORDS);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      crc_d   = crc_q;
      vld_d   = 1'b0;
      data_d  = data_q;
      done_d  = 1'b0;
      ok_d    = ok_q;
      err_d   = err_q;
      code_d  = code_q;
      if (clear_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         crc_d   = CRC_INIT;
         ok_d    = 1'b0;
         err_d   = 1'b0;
         code_d  = ERR_NONE;
      end else if (bitstream_valid_i) begin
         case (state_q)
            IDLE: begin
               if (bitstream_data_i == SYNC_WORD) begin
                  state_d = HEADER;
                  crc_d   = CRC_INIT;
                  ok_d    = 1'b0;
               end
            end
            HEADER: begin
               if (hdr_ok) begin
                  cnt_d   = hdr_len;
                  state_d = PAYLOAD;
               end else begin
                  err_d   = 1'b1;
                  code_d  = ERR_HEADER;
                  state_d = IDLE;
               end
            end
            PAYLOAD: begin
               vld_d  = 1'b1;
               data_d = bitstream_data_i;
               crc_d  = crc_next;
               cnt_d  = cnt_q - 16'd1;
               if (cnt_q == 16'd1) state_d = CRC;
            end
            CRC: begin
               done_d = 1'b1;
               if (bitstream_data_i == ~crc_q) begin
                  ok_d = 1'b1;
               end else begin
                  err_d  = 1'b1;
                  code_d = ERR_CRC;
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         crc_q   <= CRC_INIT;
         vld_q   <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         crc_q   <= crc_d;
         vld_q   <= vld_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   assign bitstream_valid_o = vld_q;
   assign bitstream_data_o  = data_q;
   assign busy_o            = (state_q != IDLE);
   assign done_o            = done_q;
   assign crc_ok_o          = ok_q;
   assign error_o           = err_q;
   assign error_code_o      = code_q;

endmodule
